// File: rtl/sysbus_arbiter_if.sv
// Sysbus master-port bundle shared by the arbiter and the top-level bus.
// The master side drives the request channel and the response acknowledge.
interface sysbus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing the Sysbus master port among fetch, data-read
// and data-writeback line transactions; one transaction in flight at a time.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [BUS_DATA_WIDTH-1:0] i_addr,
    input  logic                      dr_req,
    input  logic [BUS_DATA_WIDTH-1:0] dr_addr,
    input  logic                      dw_req,
    input  logic [BUS_DATA_WIDTH-1:0] dw_addr,
    input  logic [BUS_DATA_WIDTH-1:0] dw_wdata,
    output logic [BUS_DATA_WIDTH-1:0] rdata,
    output logic                      i_rvalid,
    output logic                      dr_rvalid,
    output logic [2:0]                beat,
    output logic                      dw_beat_en,
    output logic                      i_done,
    output logic                      dr_done,
    output logic                      dw_done,
    sysbus_arbiter_if.master          bus
);

    localparam int LINE_BITS = $clog2(BEATS * BUS_DATA_WIDTH / 8);
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_MASK = {{(BUS_DATA_WIDTH-LINE_BITS){1'b1}},
                                                       {LINE_BITS{1'b0}}};
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RESP, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_DR = 2'd2, OWN_DW = 2'd3} owner_t;

    state_t                    state, state_n;
    owner_t                    owner, rr_ptr, grant;
    logic [BUS_DATA_WIDTH-1:0] addr_q, grant_addr;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic [2:0]                cnt;
    logic                      resp_acc;

    // First asserted request at or after the round-robin pointer (order I, DR, DW).
    function automatic owner_t pick_grant(input owner_t ptr, input logic ri, input logic rdr,
                                          input logic rdw);
        pick_grant = OWN_NONE;
        unique case (ptr)
            OWN_DR: begin
                if (rdr)      pick_grant = OWN_DR;
                else if (rdw) pick_grant = OWN_DW;
                else if (ri)  pick_grant = OWN_I;
            end
            OWN_DW: begin
                if (rdw)      pick_grant = OWN_DW;
                else if (ri)  pick_grant = OWN_I;
                else if (rdr) pick_grant = OWN_DR;
            end
            default: begin
                if (ri)       pick_grant = OWN_I;
                else if (rdr) pick_grant = OWN_DR;
                else if (rdw) pick_grant = OWN_DW;
            end
        endcase
    endfunction

    // Tag layout: write flag, memory target id, requester id.
    function automatic logic [BUS_TAG_WIDTH-1:0] make_tag(input owner_t own);
        make_tag        = '0;
        make_tag[12]    = (own == OWN_DW);
        make_tag[11:8]  = 4'h1;
        make_tag[7:0]   = {6'b0, own};
    endfunction

    always_comb begin
        grant      = pick_grant(rr_ptr, i_req, dr_req, dw_req);
        grant_addr = '0;
        unique case (grant)
            OWN_I:   grant_addr = i_addr;
            OWN_DR:  grant_addr = dr_addr;
            OWN_DW:  grant_addr = dw_addr;
            default: grant_addr = '0;
        endcase
    end

    assign resp_acc = (state == RESP) && bus.bus_respcyc && (bus.bus_resptag == tag_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= OWN_I;
            owner  <= OWN_NONE;
            cnt    <= '0;
            addr_q <= '0;
            tag_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && grant != OWN_NONE) begin
                owner  <= grant;
                addr_q <= grant_addr & LINE_MASK;
                tag_q  <= make_tag(grant);
            end
            if (state == ADDR && bus.bus_reqack)
                cnt <= '0;
            else if (state == WDATA || resp_acc)
                cnt <= cnt + 3'd1;
            if (state == DONE)
                rr_ptr <= (owner == OWN_DW) ? OWN_I : owner_t'(2'(owner) + 2'd1);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (grant != OWN_NONE) state_n = ADDR;
            ADDR:    if (bus.bus_reqack) state_n = tag_q[12] ? WDATA : RESP;
            WDATA:   if (cnt == LAST_BEAT) state_n = DONE;
            RESP:    if (resp_acc && cnt == LAST_BEAT) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request channel and completion strobes decode from state; read beats pass straight through.
    always_comb begin
        bus.bus_reqcyc  = 1'b0;
        bus.bus_req     = '0;
        bus.bus_reqtag  = '0;
        bus.bus_respack = resp_acc;
        rdata           = resp_acc ? bus.bus_resp : '0;
        i_rvalid        = resp_acc && (owner == OWN_I);
        dr_rvalid       = resp_acc && (owner == OWN_DR);
        beat            = '0;
        dw_beat_en      = 1'b0;
        i_done          = 1'b0;
        dr_done         = 1'b0;
        dw_done         = 1'b0;
        unique case (state)
            ADDR: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = addr_q;
                bus.bus_reqtag = tag_q;
            end
            WDATA: begin
                bus.bus_reqcyc = 1'b1;
                bus.bus_req    = dw_wdata;
                bus.bus_reqtag = tag_q;
                dw_beat_en     = 1'b1;
                beat           = cnt;
            end
            RESP: beat = cnt;
            DONE: begin
                i_done  = (owner == OWN_I);
                dr_done = (owner == OWN_DR);
                dw_done = (owner == OWN_DW);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Randomized bench: the bench plays the three requesters and the bus slave,
// and predicts grant order, addresses, tags and beats from the arbitration rules.
module tb_sysbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, dr_req, dw_req;
    logic [63:0] i_addr, dr_addr, dw_addr, dw_wdata;
    logic [63:0] rdata;
    logic        i_rvalid, dr_rvalid;
    logic [2:0]  beat;
    logic        dw_beat_en, i_done, dr_done, dw_done;

    sysbus_arbiter_if bus_if ();

    sysbus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .dr_req     (dr_req),
        .dr_addr    (dr_addr),
        .dw_req     (dw_req),
        .dw_addr    (dw_addr),
        .dw_wdata   (dw_wdata),
        .rdata      (rdata),
        .i_rvalid   (i_rvalid),
        .dr_rvalid  (dr_rvalid),
        .beat       (beat),
        .dw_beat_en (dw_beat_en),
        .i_done     (i_done),
        .dr_done    (dr_done),
        .dw_done    (dw_done),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rr = 1;
    bit          pend [1:3];
    logic [63:0] addr_m [1:3];
    logic [63:0] wseed;

    // Requester models: hold req until done; writeback source supplies the addressed beat.
    assign i_req    = pend[1];
    assign dr_req   = pend[2];
    assign dw_req   = pend[3];
    assign i_addr   = addr_m[1];
    assign dr_addr  = addr_m[2];
    assign dw_addr  = addr_m[3];
    assign dw_wdata = wseed + 64'(beat) * 64'h0101;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tg);
        check_eq({tg, "_ctl"}, {56'd0, i_rvalid, dr_rvalid, dw_beat_en, i_done, dr_done, dw_done,
                                bus_if.bus_reqcyc, bus_if.bus_respack}, 64'd0);
        check_eq({tg, "_req"}, bus_if.bus_req, 64'd0);
        check_eq({tg, "_tag"}, 64'(bus_if.bus_reqtag), 64'd0);
        check_eq({tg, "_rdata"}, rdata, 64'd0);
        check_eq({tg, "_beat"}, 64'(beat), 64'd0);
    endtask

    // One line transaction from the IDLE cycle in which requests are visible.
    task automatic do_txn(input int ack_dly, input int n_foreign, input int rst_at, input bit fixed);
        int          own, c, k, guard, foreign, sel;
        logic [12:0] tg;
        logic [63:0] exp_a, dv;
        own = 0;
        for (int j = 0; j < 3; j++) begin
            c = ((rr - 1 + j) % 3) + 1;
            if (own == 0 && pend[c]) own = c;
        end
        if (own == 0) return;
        tg    = {(own == 3), 4'h1, 8'(own)};
        exp_a = addr_m[own] & ~64'h3f;
        check_eq("idle_reqcyc", 64'(bus_if.bus_reqcyc), 64'd0);
        next();
        for (int d = 0; d <= ack_dly; d++) begin
            check_eq("addr_cyc", 64'(bus_if.bus_reqcyc), 64'd1);
            check_eq("addr_req", bus_if.bus_req, exp_a);
            check_eq("addr_tag", 64'(bus_if.bus_reqtag), 64'(tg));
            if (d == ack_dly) bus_if.bus_reqack = 1'b1;
            next();
            bus_if.bus_reqack = 1'b0;
        end
        if (own == 3) begin
            for (int b = 0; b < 8; b++) begin
                bus_if.bus_respcyc = 1'b1;
                bus_if.bus_resptag = tg;
                #1;
                check_eq("wr_cyc", 64'(bus_if.bus_reqcyc), 64'd1);
                check_eq("wr_data", bus_if.bus_req, wseed + 64'(b) * 64'h0101);
                check_eq("wr_tag", 64'(bus_if.bus_reqtag), 64'(tg));
                check_eq("wr_en", 64'(dw_beat_en), 64'd1);
                check_eq("wr_beat", 64'(beat), 64'(b));
                check_eq("wr_respack", 64'(bus_if.bus_respack), 64'd0);
                next();
            end
            bus_if.bus_respcyc = 1'b0;
        end else begin
            k       = 0;
            guard   = 0;
            foreign = n_foreign;
            while (k < 8) begin
                guard++;
                if (guard > 80) begin
                    check_eq("rd_timeout", 64'(k), 64'd8);
                    break;
                end
                sel = $urandom_range(0, 3);
                if (foreign > 0 && sel < 2) begin
                    bus_if.bus_respcyc = 1'b1;
                    bus_if.bus_resptag = tg ^ 13'h0003;
                    bus_if.bus_resp    = {$urandom, $urandom};
                    #1;
                    check_eq("fgn_respack", 64'(bus_if.bus_respack), 64'd0);
                    check_eq("fgn_rvalid", 64'({i_rvalid, dr_rvalid}), 64'd0);
                    foreign--;
                end else if (sel == 3) begin
                    bus_if.bus_respcyc = 1'b0;
                    bus_if.bus_resptag = tg;
                    #1;
                    check_eq("gap_respack", 64'(bus_if.bus_respack), 64'd0);
                    check_eq("gap_rvalid", 64'({i_rvalid, dr_rvalid}), 64'd0);
                end else begin
                    dv = fixed ? 64'(k + 1) * 64'h11 : {$urandom, $urandom};
                    bus_if.bus_respcyc = 1'b1;
                    bus_if.bus_resptag = tg;
                    bus_if.bus_resp    = dv;
                    if (k == rst_at) begin
                        reset = 1'b1;
                        next();
                        reset = 1'b0;
                        bus_if.bus_respcyc = 1'b0;
                        #1;
                        check_zero("mid_rst");
                        rr = 1;
                        return;
                    end
                    #1;
                    check_eq("rd_respack", 64'(bus_if.bus_respack), 64'd1);
                    check_eq("rd_rvalid", 64'({i_rvalid, dr_rvalid}), (own == 1) ? 64'd2 : 64'd1);
                    check_eq("rd_data", rdata, dv);
                    check_eq("rd_beat", 64'(beat), 64'(k));
                    k++;
                end
                next();
            end
            bus_if.bus_respcyc = 1'b0;
        end
        check_eq("done", 64'({i_done, dr_done, dw_done}), 64'(1 << (3 - own)));
        check_eq("done_reqcyc", 64'(bus_if.bus_reqcyc), 64'd0);
        next();
        pend[own] = 1'b0;
        rr = own % 3 + 1;
        check_eq("done_pulse", 64'({i_done, dr_done, dw_done}), 64'd0);
    endtask

    initial begin
        reset              = 1'b1;
        pend               = '{default: 1'b0};
        addr_m             = '{default: 64'd0};
        wseed              = 64'd0;
        bus_if.bus_reqack  = 1'b0;
        bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp    = 64'd0;
        bus_if.bus_resptag = 13'd0;
        repeat (2) next();
        check_zero("reset");
        reset = 1'b0;
        next();

        // Single fetch with a fixed beat pattern and a two-cycle ack delay.
        pend[1] = 1'b1; addr_m[1] = 64'h1000_0047;
        do_txn(2, 0, -1, 1'b1);
        // Writeback with beat-index data.
        pend[3] = 1'b1; addr_m[3] = 64'h2000; wseed = 64'd0;
        do_txn(0, 0, -1, 1'b0);
        // Data read interleaved with foreign-tag beats.
        pend[2] = 1'b1; addr_m[2] = 64'h3000_00ff;
        do_txn(0, 3, -1, 1'b1);
        // Long address-phase stall.
        pend[1] = 1'b1; addr_m[1] = 64'h4444_0080;
        do_txn(5, 0, -1, 1'b0);

        // Contention from reset, with fetch re-requesting immediately.
        reset = 1'b1;
        pend[1] = 1'b1; pend[2] = 1'b1; pend[3] = 1'b1;
        addr_m[1] = 64'h100; addr_m[2] = 64'h200; addr_m[3] = 64'h300; wseed = 64'h5a00;
        next();
        reset = 1'b0;
        rr = 1;
        do_txn(1, 0, -1, 1'b0);
        pend[1] = 1'b1;
        do_txn(0, 1, -1, 1'b0);
        pend[1] = 1'b1;
        do_txn(0, 0, -1, 1'b0);
        do_txn(0, 0, -1, 1'b0);

        // Reset during read beat 3, then the still-held request is served again.
        pend[2] = 1'b1; addr_m[2] = 64'h7777_7000;
        do_txn(1, 0, 3, 1'b0);
        do_txn(0, 0, -1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            for (int c = 1; c <= 3; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c]   = 1'b1;
                    addr_m[c] = {$urandom, $urandom};
                end
            end
            if (!pend[1] && !pend[2] && !pend[3]) pend[$urandom_range(1, 3)] = 1'b1;
            wseed = {$urandom, $urandom};
            do_txn($urandom_range(0, 3), $urandom_range(0, 2), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d comparisons made", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
